// File: rtl/tri_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tri_gen_ctrl
// Brief    : Phase sequencer driving an external up/down counter through
//            load, rise, top dwell, fall and bottom dwell phases. Turnaround
//            dwell is compiled in only when TRI_GEN_CTRL_DWELL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tri_gen_ctrl #(
    parameter int DW      = 9,
    parameter int DWELL_W = 8,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic               stop,
    input  logic [DW-1:0]      cfg_floor,
    input  logic [DW-1:0]      cfg_peak,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [CNT_W-1:0]   cfg_periods,
    input  logic [DW-1:0]      d_in,
    output logic               cnt_ld,
    output logic [DW-1:0]      ld_val,
    output logic               cnt_en,
    output logic               cnt_up,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [CNT_W-1:0]   period_cnt
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_RISE     = 3'd2,
        S_HOLD_TOP = 3'd3,
        S_FALL     = 3'd4,
        S_HOLD_BOT = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    localparam logic [DW-1:0]    c_DATA_ONE = DW'(1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_nxt_state;
    logic [DW-1:0]    r_peak;
    logic [DW-1:0]    r_floor;
    logic [CNT_W-1:0] r_periods;
    logic [CNT_W-1:0] r_period_cnt;
    logic             r_err;
    logic             r_cnt_ld;
    logic             r_cnt_en;
    logic             r_cnt_up;
    logic             r_busy;
    logic             r_done;

    logic             w_start_acc;
    logic             w_reject;
    logic             w_stop_req;
    logic             w_at_top;
    logic             w_at_bot;
    logic             w_dwell_zero;
    logic [CNT_W-1:0] w_pc_inc;
    logic             w_last_inc;

    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_reject    = (cfg_peak <= cfg_floor);
    assign w_stop_req  = stop && (r_state != S_IDLE) && (r_state != S_DONE);
    // The step taken on the edge that leaves RISE/FALL lands exactly on the limit.
    assign w_at_top    = (d_in == (r_peak - c_DATA_ONE));
    assign w_at_bot    = (d_in == (r_floor + c_DATA_ONE));
    assign w_pc_inc    = (r_period_cnt == c_CNT_MAX) ? r_period_cnt : (r_period_cnt + c_CNT_ONE);
    assign w_last_inc  = (r_periods != '0) && (w_pc_inc == r_periods);

`ifdef TRI_GEN_CTRL_DWELL_EN
    localparam logic [DWELL_W-1:0] c_DWELL_ONE = DWELL_W'(1);

    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_dwell_cnt;
    logic               w_hold_done;
    logic               w_last_now;

    assign w_dwell_zero = (r_dwell == '0);
    assign w_hold_done  = (r_dwell_cnt == '0);
    assign w_last_now   = (r_periods != '0) && (r_period_cnt == r_periods);

    // Hold counter is preloaded with dwell-1 on entry so a hold lasts dwell cycles.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_dwell     <= '0;
            r_dwell_cnt <= '0;
        end else begin
            if (w_start_acc) begin
                r_dwell <= cfg_dwell;
            end
            if ((w_nxt_state == S_HOLD_TOP) || (w_nxt_state == S_HOLD_BOT)) begin
                r_dwell_cnt <= (r_state == w_nxt_state) ? (r_dwell_cnt - c_DWELL_ONE)
                                                        : (r_dwell - c_DWELL_ONE);
            end
        end
    end
`else
    logic w_unused_dwell;

    assign w_unused_dwell = ^cfg_dwell;
    assign w_dwell_zero   = 1'b1;
`endif

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nxt_state = w_reject ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                w_nxt_state = S_RISE;
            end
            S_RISE: begin
                if (w_at_top) begin
                    w_nxt_state = w_dwell_zero ? S_FALL : S_HOLD_TOP;
                end
            end
            S_FALL: begin
                if (w_at_bot) begin
                    if (!w_dwell_zero) begin
                        w_nxt_state = S_HOLD_BOT;
                    end else begin
                        w_nxt_state = w_last_inc ? S_DONE : S_RISE;
                    end
                end
            end
`ifdef TRI_GEN_CTRL_DWELL_EN
            S_HOLD_TOP: begin
                if (w_hold_done) begin
                    w_nxt_state = S_FALL;
                end
            end
            S_HOLD_BOT: begin
                if (w_hold_done) begin
                    w_nxt_state = w_last_now ? S_DONE : S_RISE;
                end
            end
`endif
            S_DONE: begin
                w_nxt_state = S_IDLE;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
        if (w_stop_req) begin
            w_nxt_state = S_DONE;
        end
    end

    // Moore outputs are registered from the next state so they track r_state exactly.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state      <= S_IDLE;
            r_cnt_ld     <= 1'b0;
            r_cnt_en     <= 1'b0;
            r_cnt_up     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_peak       <= '0;
            r_floor      <= '0;
            r_periods    <= '0;
            r_period_cnt <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_cnt_ld <= (w_nxt_state == S_LOAD);
            r_cnt_en <= (w_nxt_state == S_RISE) || (w_nxt_state == S_FALL);
            r_cnt_up <= (w_nxt_state == S_RISE);
            r_busy   <= (w_nxt_state != S_IDLE);
            r_done   <= (w_nxt_state == S_DONE);
            if (w_start_acc) begin
                r_peak       <= cfg_peak;
                r_floor      <= cfg_floor;
                r_periods    <= cfg_periods;
                r_period_cnt <= '0;
                r_err        <= w_reject;
            end else if ((r_state == S_FALL) && w_at_bot && !w_stop_req) begin
                r_period_cnt <= w_pc_inc;
            end
        end
    end

    assign cnt_ld     = r_cnt_ld;
    assign cnt_en     = r_cnt_en;
    assign cnt_up     = r_cnt_up;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign ld_val     = r_floor;
    assign period_cnt = r_period_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tri_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_tri_gen_ctrl
// Brief    : Self-checking bench for tri_gen_ctrl with a behavioural counter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tri_gen_ctrl;

`ifdef TRI_GEN_CTRL_DWELL_EN
    localparam bit DWELL_ON = 1'b1;
`else
    localparam bit DWELL_ON = 1'b0;
`endif

    // ctl bit order: {cnt_ld, cnt_en, cnt_up, busy, done, err}
    typedef struct {
        logic [5:0] ctl;
        logic [8:0] d;
        bit         chk_d;
        logic [7:0] pc;
        bit         drv_stop;
        bit         drv_start;
    } exp_t;

    logic       clk = 1'b0;
    logic       res = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [8:0] cfg_floor = '0;
    logic [8:0] cfg_peak = '0;
    logic [7:0] cfg_dwell = '0;
    logic [7:0] cfg_periods = '0;
    logic [8:0] d_in;
    logic       cnt_ld, cnt_en, cnt_up, busy, done, err;
    logic [8:0] ld_val;
    logic [7:0] period_cnt;
    logic [8:0] q = 9'd0;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];

    tri_gen_ctrl #(.DW(9), .DWELL_W(8), .CNT_W(8)) dut (
        .clk(clk), .res(res), .start(start), .stop(stop),
        .cfg_floor(cfg_floor), .cfg_peak(cfg_peak), .cfg_dwell(cfg_dwell),
        .cfg_periods(cfg_periods), .d_in(d_in), .cnt_ld(cnt_ld), .ld_val(ld_val),
        .cnt_en(cnt_en), .cnt_up(cnt_up), .busy(busy), .done(done), .err(err),
        .period_cnt(period_cnt)
    );

    always #5 clk = ~clk;

    // External counter: not reset, keeps its value across controller reset.
    always @(posedge clk) begin
        if (cnt_ld)      q <= ld_val;
        else if (cnt_en) q <= cnt_up ? q + 9'd1 : q - 9'd1;
    end
    assign d_in = q;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [5:0] ctl, input int d, input bit chk, input int pc);
        exp_t e;
        e.ctl = ctl;
        e.d = d[8:0];
        e.chk_d = chk;
        e.pc = (pc > 255) ? 8'hFF : pc[7:0];
        e.drv_stop = 1'b0;
        e.drv_start = 1'b0;
        return e;
    endfunction

    function automatic logic [22:0] obs(input bit chk);
        return {cnt_ld, cnt_en, cnt_up, busy, done, err, (chk ? d_in : 9'd0), period_cnt};
    endfunction

    function automatic logic [22:0] expw(input exp_t e);
        return {e.ctl, (e.chk_d ? e.d : 9'd0), e.pc};
    endfunction

    // Expected per-cycle trace of a run from cycle 1 (LOAD) through the idle cycle after DONE.
    task automatic push_run(input int fl, input int pk, input int dw, input int np,
                            input int stop_at, input bit busy_start);
        exp_t t[$];
        exp_t e;
        int   span = pk - fl;
        int   d;
        int   pc;
        t.push_back(mk(6'b100100, 0, 1'b0, 0));
        for (int p = 0; p < np; p++) begin
            for (int i = 0; i < span; i++) t.push_back(mk(6'b011100, fl + i, 1'b1, p));
            for (int i = 0; i < dw; i++)   t.push_back(mk(6'b000100, pk, 1'b1, p));
            for (int i = 0; i < span; i++) t.push_back(mk(6'b010100, pk - i, 1'b1, p));
            for (int i = 0; i < dw; i++)   t.push_back(mk(6'b000100, fl, 1'b1, p + 1));
        end
        if (stop_at > 0) begin
            while (t.size() > stop_at) void'(t.pop_back());
            t[stop_at-1].drv_stop = 1'b1;
            e  = t[stop_at-1];
            d  = int'(e.d);
            if (e.ctl[4]) d = e.ctl[3] ? d + 1 : d - 1;
            pc = int'(e.pc);
        end else begin
            d  = fl;
            pc = np;
        end
        t.push_back(mk(6'b000110, d, 1'b1, pc));
        if (busy_start) foreach (t[i]) t[i].drv_start = 1'b1;
        t.push_back(mk(6'b000000, d, 1'b1, pc));
        foreach (t[i]) sb.push_back(t[i]);
    endtask

    task automatic set_cfg(input int fl, input int pk, input int dw, input int np);
        cfg_floor   = fl[8:0];
        cfg_peak    = pk[8:0];
        cfg_dwell   = dw[7:0];
        cfg_periods = np[7:0];
    endtask

    task automatic kick();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        res = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cnt_ld, cnt_en, cnt_up, busy, done, err, period_cnt, ld_val} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {cnt_ld, cnt_en, cnt_up, busy, done, err, period_cnt, ld_val});
        end
        res = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({cnt_ld, cnt_en, cnt_up, busy, done, err} !== 6'd0) begin
            failures++;
            $display("FAIL reset_release got=%b exp=000000", {cnt_ld, cnt_en, cnt_up, busy, done, err});
        end
    endtask

    task automatic test_basic();
        exp_t e;
        int   cyc = 1;
        int   dwe = DWELL_ON ? 3 : 0;
        set_cfg(10, 20, 3, 2);
        push_run(10, 20, dwe, 2, 0, 1'b0);
        kick();
        set_cfg(0, 300, 9, 1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL basic cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_dwell0();
        exp_t e;
        int   cyc = 1;
        set_cfg(5, 6, 0, 3);
        push_run(5, 6, 0, 3, 0, 1'b0);
        stop = 1'b1;
        kick();
        stop = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL dwell0 cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reject();
        exp_t e;
        int   cyc = 1;
        set_cfg(7, 7, 2, 1);
        sb.push_back(mk(6'b000111, 0, 1'b0, 0));
        sb.push_back(mk(6'b000001, 0, 1'b0, 0));
        sb.push_back(mk(6'b000001, 0, 1'b0, 0));
        kick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL reject cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_stop();
        exp_t e;
        int   cyc = 1;
        int   dwe = DWELL_ON ? 2 : 0;
        int   per = 2 * (14 - 10) + 2 * dwe;
        int   stop_at = 2 + 3 * per + (14 - 10) + dwe + 2;
        set_cfg(10, 14, 2, 0);
        push_run(10, 14, dwe, 5, stop_at, 1'b0);
        kick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL stop cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_saturation();
        exp_t e;
        int   cyc = 1;
        int   stop_at = 2 + 2 * 258;
        set_cfg(5, 6, 0, 0);
        push_run(5, 6, 0, 260, stop_at, 1'b0);
        kick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL saturation cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int   cyc = 1;
        int   dwe = DWELL_ON ? 2 : 0;
        set_cfg(10, 20, 2, 1);
        kick();
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if ({cnt_en, cnt_up, d_in} !== {2'b11, 9'd13}) begin
            failures++;
            $display("FAIL midrun_pre got=%h exp=%h", {cnt_en, cnt_up, d_in}, {2'b11, 9'd13});
        end
        res = 1'b0;
        #1;
        checks++;
        if ({cnt_ld, cnt_en, cnt_up, busy, done, err, period_cnt, ld_val} !== 23'd0) begin
            failures++;
            $display("FAIL midrun_async got=%h exp=0", {cnt_ld, cnt_en, cnt_up, busy, done, err, period_cnt, ld_val});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cnt_ld, cnt_en, cnt_up, busy, done, err, d_in} !== {6'd0, 9'd13}) begin
            failures++;
            $display("FAIL midrun_hold got=%h exp=%h", {cnt_ld, cnt_en, cnt_up, busy, done, err, d_in}, {6'd0, 9'd13});
        end
        res = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, cnt_ld, cnt_en} !== 3'b000) begin
            failures++;
            $display("FAIL midrun_release got=%b exp=000", {busy, cnt_ld, cnt_en});
        end
        push_run(10, 20, dwe, 1, 0, 1'b1);
        kick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL restart cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    task automatic test_nodwell();
        exp_t e;
        int   cyc = 1;
        int   dwe = DWELL_ON ? 5 : 0;
        set_cfg(5, 6, 5, 3);
        push_run(5, 6, dwe, 3, 0, 1'b0);
        kick();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (obs(e.chk_d) !== expw(e)) begin
                failures++;
                $display("FAIL nodwell cycle=%0d got=%h exp=%h", cyc, obs(e.chk_d), expw(e));
            end
            start = e.drv_start; stop = e.drv_stop;
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; stop = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_dwell0();
        test_reject();
        test_stop();
        test_saturation();
        test_reset_midrun();
        test_nodwell();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
